// File: rtl/srlatch_pkg.sv
// Shared types and S/R encoding helpers for the SR latch bank writer.
package srlatch_pkg;

  localparam int unsigned SR_WIDTH_DEFAULT = 4;

  typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, GAP} sr_wr_state_t;

  // One bit: {S,R}. Masked-off bits hold (S=R=1); S=R=0 is never produced.
  function automatic logic [1:0] sr_encode_bit(input logic data, input logic mask);
    logic [1:0] sr;
    if (!mask)     sr = 2'b11;
    else if (data) sr = 2'b10;
    else           sr = 2'b01;
    return sr;
  endfunction

  // Whole default-width word: returns {S,R}.
  function automatic logic [2*SR_WIDTH_DEFAULT-1:0] sr_encode(
    input logic [SR_WIDTH_DEFAULT-1:0] data,
    input logic [SR_WIDTH_DEFAULT-1:0] mask
  );
    logic [SR_WIDTH_DEFAULT-1:0] s;
    logic [SR_WIDTH_DEFAULT-1:0] r;
    for (int i = 0; i < int'(SR_WIDTH_DEFAULT); i++) begin
      {s[i], r[i]} = sr_encode_bit(data[i], mask[i]);
    end
    return {s, r};
  endfunction

endpackage

// File: rtl/sr_phase_timer.sv
// Loadable down-counter with terminal-count flag; times PULSE and GAP phases.
module sr_phase_timer #(
  parameter int unsigned CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_tc_c
);

  logic [CNT_W-1:0] r_cnt;

  // Reload on phase entry, count down, saturate at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_tc_c = (r_cnt == '0);

endmodule

// File: rtl/srlatch_4_writer.sv
// Sequencer turning masked write requests into safe S/R/En waveforms for the SR latch bank.
module srlatch_4_writer
  import srlatch_pkg::*;
#(
  parameter int WIDTH     = int'(SR_WIDTH_DEFAULT),
  parameter int PULSE_CYC = 2,
  parameter int GAP_CYC   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [WIDTH-1:0] in_mask,
  input  logic             clr,
  output logic [WIDTH-1:0] S,
  output logic [WIDTH-1:0] R,
  output logic             En,
  output logic             busy,
  output logic             done
);

  localparam int          MAX_CYC    = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
  localparam int unsigned CNT_W      = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = (GAP_CYC > 0) ? CNT_W'(GAP_CYC - 1) : '0;

  if (PULSE_CYC < 1) begin : g_bad_pulse
    $error("srlatch_4_writer: PULSE_CYC must be >= 1");
  end
  if (GAP_CYC < 0) begin : g_bad_gap
    $error("srlatch_4_writer: GAP_CYC must be >= 0");
  end

  sr_wr_state_t     r_state;
  logic [WIDTH-1:0] r_s;
  logic [WIDTH-1:0] r_r;
  logic             r_en;
  logic             r_done;
  logic             r_clr_pending;

  sr_wr_state_t     w_state_nxt;
  logic [WIDTH-1:0] w_s_nxt;
  logic [WIDTH-1:0] w_r_nxt;
  logic             w_en_nxt;
  logic             w_done_nxt;
  logic             w_clr_pend_nxt;
  logic             w_take_clr;
  logic [WIDTH-1:0] w_wr_data;
  logic [WIDTH-1:0] w_wr_mask;
  logic [WIDTH-1:0] w_enc_s;
  logic [WIDTH-1:0] w_enc_r;
  logic             w_tmr_load;
  logic [CNT_W-1:0] w_tmr_val;
  logic             w_tmr_dec;
  logic             w_tmr_tc;

  sr_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .i_dec      (w_tmr_dec),
    .o_tc_c     (w_tmr_tc)
  );

  // Pending clears win over new writes; a clear is data=0 with every bit enabled.
  assign w_take_clr = clr | r_clr_pending;
  assign w_wr_data  = w_take_clr ? '0 : in_data;
  assign w_wr_mask  = w_take_clr ? '1 : in_mask;

  // Per-bit S/R pattern for the request being accepted.
  always_comb begin
    w_enc_s = '1;
    w_enc_r = '1;
    for (int i = 0; i < WIDTH; i++) begin
      {w_enc_s[i], w_enc_r[i]} = sr_encode_bit(w_wr_data[i], w_wr_mask[i]);
    end
  end

  // Next-state and registered-output values.
  always_comb begin
    w_state_nxt    = r_state;
    w_s_nxt        = r_s;
    w_r_nxt        = r_r;
    w_en_nxt       = 1'b0;
    w_done_nxt     = 1'b0;
    w_clr_pend_nxt = r_clr_pending;
    w_tmr_load     = 1'b0;
    w_tmr_val      = '0;
    w_tmr_dec      = 1'b0;

    if (clr && (r_state != IDLE)) begin
      w_clr_pend_nxt = 1'b1;
    end

    case (r_state)
      IDLE: begin
        w_s_nxt = '1;
        w_r_nxt = '1;
        if (w_take_clr || in_valid) begin
          w_s_nxt        = w_enc_s;
          w_r_nxt        = w_enc_r;
          w_clr_pend_nxt = 1'b0;
          w_state_nxt    = SETUP;
        end
      end
      SETUP: begin
        w_en_nxt    = 1'b1;
        w_tmr_load  = 1'b1;
        w_tmr_val   = PULSE_LOAD;
        w_state_nxt = PULSE;
      end
      PULSE: begin
        if (w_tmr_tc) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = HOLD;
        end else begin
          w_en_nxt  = 1'b1;
          w_tmr_dec = 1'b1;
        end
      end
      HOLD: begin
        w_s_nxt = '1;
        w_r_nxt = '1;
        if (GAP_CYC == 0) begin
          w_state_nxt = IDLE;
        end else begin
          w_tmr_load  = 1'b1;
          w_tmr_val   = GAP_LOAD;
          w_state_nxt = GAP;
        end
      end
      GAP: begin
        if (w_tmr_tc) begin
          w_state_nxt = IDLE;
        end else begin
          w_tmr_dec = 1'b1;
        end
      end
      default: begin
        w_s_nxt     = '1;
        w_r_nxt     = '1;
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State and output registers; reset returns to the idle hold encoding.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_s           <= '1;
      r_r           <= '1;
      r_en          <= 1'b0;
      r_done        <= 1'b0;
      r_clr_pending <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_s           <= w_s_nxt;
      r_r           <= w_r_nxt;
      r_en          <= w_en_nxt;
      r_done        <= w_done_nxt;
      r_clr_pending <= w_clr_pend_nxt;
    end
  end

  assign in_ready = (r_state == IDLE) & ~rst;
  assign busy     = (r_state != IDLE);
  assign S        = r_s;
  assign R        = r_r;
  assign En       = r_en;
  assign done     = r_done;

endmodule

// File: tb/tb_srlatch_4_writer.sv
// Bench for srlatch_4_writer: two instances (2/1 and 1/0 timing) driving modelled latch banks.
module tb_srlatch_4_writer;

  localparam int P_A = 2;
  localparam int G_A = 1;
  localparam int P_B = 1;
  localparam int G_B = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       in_valid = 1'b0, clr = 1'b0;
  logic [3:0] in_data = '0, in_mask = '0;
  logic       in_ready, En, busy, done;
  logic [3:0] S, R;

  logic       in_valid_b = 1'b0, clr_b = 1'b0;
  logic [3:0] in_data_b = '0, in_mask_b = '0;
  logic       in_ready_b, En_b, busy_b, done_b;
  logic [3:0] S_b, R_b;

  int n_vec = 0;
  int n_err = 0;

  logic [3:0] q_lat = '0, q_lat_b = '0;
  logic [3:0] q_exp = '0;
  int viol = 0, viol_b = 0;
  logic [3:0] s_last, r_last, s_last_b, r_last_b;
  logic en_last = 1'b0, en_last_b = 1'b0;

  always #5 clk = ~clk;

  srlatch_4_writer #(.WIDTH(4), .PULSE_CYC(P_A), .GAP_CYC(G_A)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_mask(in_mask), .clr(clr),
    .S(S), .R(R), .En(En), .busy(busy), .done(done)
  );

  srlatch_4_writer #(.WIDTH(4), .PULSE_CYC(P_B), .GAP_CYC(G_B)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_data(in_data_b), .in_mask(in_mask_b), .clr(clr_b),
    .S(S_b), .R(R_b), .En(En_b), .busy(busy_b), .done(done_b)
  );

  // Downstream latch banks: S-only sets, R-only resets, both high holds; flag unsafe patterns.
  always @(negedge clk) begin
    if (En === 1'b1) begin
      for (int i = 0; i < 4; i++) begin
        if (S[i] && !R[i]) q_lat[i] = 1'b1;
        else if (!S[i] && R[i]) q_lat[i] = 1'b0;
        else if (!S[i] && !R[i]) viol++;
      end
      if (en_last && ((S !== s_last) || (R !== r_last))) viol++;
    end
    en_last = (En === 1'b1); s_last = S; r_last = R;
    if (En_b === 1'b1) begin
      for (int i = 0; i < 4; i++) begin
        if (S_b[i] && !R_b[i]) q_lat_b[i] = 1'b1;
        else if (!S_b[i] && R_b[i]) q_lat_b[i] = 1'b0;
        else if (!S_b[i] && !R_b[i]) viol_b++;
      end
      if (en_last_b && ((S_b !== s_last_b) || (R_b !== r_last_b))) viol_b++;
    end
    en_last_b = (En_b === 1'b1); s_last_b = S_b; r_last_b = R_b;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected {S,R} from the per-bit write table.
  function automatic logic [7:0] exp_sr(input logic [3:0] d, input logic [3:0] m);
    logic [3:0] s, r;
    for (int i = 0; i < 4; i++) begin
      if (!m[i])     begin s[i] = 1'b1; r[i] = 1'b1; end
      else if (d[i]) begin s[i] = 1'b1; r[i] = 1'b0; end
      else           begin s[i] = 1'b0; r[i] = 1'b1; end
    end
    return {s, r};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    n_vec++; if (S !== 4'b1111) begin n_err++; $display("FAIL rst_S got %b exp 1111", S); end
    n_vec++; if (R !== 4'b1111) begin n_err++; $display("FAIL rst_R got %b exp 1111", R); end
    n_vec++; if (En !== 1'b0) begin n_err++; $display("FAIL rst_En got %b exp 0", En); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got %b exp 0", busy); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL rst_done got %b exp 0", done); end
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready_in_rst got %b exp 0", in_ready); end
    rst = 1'b0;
    #1;
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready_after got %b exp 1", in_ready); end
    n_vec++; if (in_ready_b !== 1'b1) begin n_err++; $display("FAIL rst_ready_b_after got %b exp 1", in_ready_b); end
    step();
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy_post got %b exp 0", busy); end
  endtask

  // One full write on instance A with phase-by-phase timing checks.
  task automatic run_write(input logic [3:0] d, input logic [3:0] m);
    logic [7:0] sr;
    logic [3:0] es, er;
    int t;
    sr = exp_sr(d, m); es = sr[7:4]; er = sr[3:0];
    t = 0;
    while ((in_ready !== 1'b1) && (t < 20)) begin step(); t++; end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL wr_ready_wait got %b exp 1", in_ready); end
    in_data = d; in_mask = m; in_valid = 1'b1;
    step();
    in_valid = 1'b0; in_data = 4'($urandom); in_mask = 4'($urandom);
    n_vec++; if (S !== es) begin n_err++; $display("FAIL wr_setup_S d=%b m=%b got %b exp %b", d, m, S, es); end
    n_vec++; if (R !== er) begin n_err++; $display("FAIL wr_setup_R d=%b m=%b got %b exp %b", d, m, R, er); end
    n_vec++; if (En !== 1'b0) begin n_err++; $display("FAIL wr_setup_En got %b exp 0", En); end
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL wr_setup_busy got %b exp 1", busy); end
    for (int p = 0; p < P_A; p++) begin
      step();
      n_vec++; if (En !== 1'b1) begin n_err++; $display("FAIL wr_pulse_En p=%0d got %b exp 1", p, En); end
      n_vec++; if ({S, R} !== {es, er}) begin n_err++; $display("FAIL wr_pulse_SR p=%0d got %b/%b exp %b/%b", p, S, R, es, er); end
      n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL wr_pulse_done p=%0d got %b exp 0", p, done); end
    end
    step();
    n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL wr_hold_done got %b exp 1", done); end
    n_vec++; if (En !== 1'b0) begin n_err++; $display("FAIL wr_hold_En got %b exp 0", En); end
    n_vec++; if ({S, R} !== {es, er}) begin n_err++; $display("FAIL wr_hold_SR got %b/%b exp %b/%b", S, R, es, er); end
    for (int g = 0; g < G_A; g++) begin
      step();
      n_vec++; if ({S, R, En, done} !== 10'b1111111100) begin n_err++; $display("FAIL wr_gap g=%0d got S=%b R=%b En=%b done=%b exp idle", g, S, R, En, done); end
    end
    step();
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL wr_ready_again got %b exp 1", in_ready); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL wr_idle_busy got %b exp 0", busy); end
    q_exp = (q_exp & ~m) | (d & m);
    n_vec++; if (q_lat !== q_exp) begin n_err++; $display("FAIL wr_Q got %b exp %b", q_lat, q_exp); end
  endtask

  task automatic test_write_full();
    run_write(4'b1010, 4'b1111);
  endtask

  task automatic test_write_masked();
    run_write(4'b0011, 4'b0101);
    n_vec++; if (q_lat !== 4'b1011) begin n_err++; $display("FAIL masked_Q got %b exp 1011", q_lat); end
    for (int k = 0; k < 3; k++) run_write(4'($urandom), 4'($urandom));
  endtask

  // Clear pulses during a write collapse into one clear, served before the waiting write.
  task automatic test_clr_pending();
    logic [7:0] seen[$];
    int n_done, n_ready;
    logic drop, en_prev;
    n_done = 0; n_ready = 0; drop = 1'b0; en_prev = 1'b0;
    in_data = 4'b0110; in_mask = 4'b1111; in_valid = 1'b1;
    step();
    in_data = 4'b1111; in_mask = 4'b1111;
    for (int k = 1; k < 30; k++) begin
      step();
      if (drop) begin in_valid = 1'b0; drop = 1'b0; end
      if (in_ready === 1'b1) begin n_ready++; if (n_ready == 2) drop = 1'b1; end
      if (done === 1'b1) n_done++;
      if ((En === 1'b1) && !en_prev) seen.push_back({S, R});
      en_prev = (En === 1'b1);
      if (k == 1) clr = 1'b1;
      if (k == 2) clr = 1'b0;
      if (k == 3) clr = 1'b1;
      if (k == 4) clr = 1'b0;
    end
    n_vec++; if (n_done !== 3) begin n_err++; $display("FAIL clr_done_count got %0d exp 3", n_done); end
    n_vec++; if (seen.size() !== 3) begin n_err++; $display("FAIL clr_pulse_count got %0d exp 3", seen.size()); end
    if (seen.size() >= 3) begin
      n_vec++; if (seen[0] !== exp_sr(4'b0110, 4'b1111)) begin n_err++; $display("FAIL clr_first_SR got %b exp %b", seen[0], exp_sr(4'b0110, 4'b1111)); end
      n_vec++; if (seen[1] !== 8'b0000_1111) begin n_err++; $display("FAIL clr_clear_SR got %b exp 00001111", seen[1]); end
      n_vec++; if (seen[2] !== 8'b1111_0000) begin n_err++; $display("FAIL clr_write_SR got %b exp 11110000", seen[2]); end
    end
    q_exp = 4'b1111;
    n_vec++; if (q_lat !== 4'b1111) begin n_err++; $display("FAIL clr_final_Q got %b exp 1111", q_lat); end
  endtask

  // Reset on the second PULSE cycle aborts at once with no done pulse.
  task automatic test_reset_mid();
    logic [3:0] d;
    d = 4'($urandom);
    in_data = d; in_mask = 4'b1111; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step();
    n_vec++; if (En !== 1'b1) begin n_err++; $display("FAIL abort_pre_En got %b exp 1", En); end
    rst = 1'b1;
    step();
    n_vec++; if (En !== 1'b0) begin n_err++; $display("FAIL abort_En got %b exp 0", En); end
    n_vec++; if ({S, R} !== 8'hFF) begin n_err++; $display("FAIL abort_SR got %b/%b exp 1111/1111", S, R); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL abort_done got %b exp 0", done); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy got %b exp 0", busy); end
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      n_vec++; if ((done !== 1'b0) || (busy !== 1'b0)) begin n_err++; $display("FAIL abort_quiet k=%0d got done=%b busy=%b exp 0/0", k, done, busy); end
    end
    q_exp = d;
    n_vec++; if (q_lat !== q_exp) begin n_err++; $display("FAIL abort_Q got %b exp %b", q_lat, q_exp); end
  endtask

  // Eight random writes streamed into instance B with in_valid held high.
  task automatic test_back_to_back();
    logic [3:0] rd[8], rm[8], qe[8], q;
    int idx, n_done, last, spacing;
    logic acc;
    spacing = 3 + P_B + G_B;
    q = q_lat_b;
    for (int i = 0; i < 8; i++) begin
      rd[i] = 4'($urandom); rm[i] = 4'($urandom);
      q = (q & ~rm[i]) | (rd[i] & rm[i]);
      qe[i] = q;
    end
    idx = 0; n_done = 0; last = 0;
    in_data_b = rd[0]; in_mask_b = rm[0]; in_valid_b = 1'b1;
    for (int cyc = 0; cyc < 60; cyc++) begin
      acc = (in_ready_b === 1'b1) && in_valid_b;
      step();
      if (acc) begin
        idx++;
        if (idx < 8) begin in_data_b = rd[idx]; in_mask_b = rm[idx]; end
        else in_valid_b = 1'b0;
      end
      if (done_b === 1'b1) begin
        if (n_done > 0) begin
          n_vec++; if ((cyc - last) !== spacing) begin n_err++; $display("FAIL b2b_spacing n=%0d got %0d exp %0d", n_done, cyc - last, spacing); end
        end
        if (n_done < 8) begin
          n_vec++; if (q_lat_b !== qe[n_done]) begin n_err++; $display("FAIL b2b_Q n=%0d got %b exp %b", n_done, q_lat_b, qe[n_done]); end
        end
        n_done++;
        last = cyc;
      end
    end
    n_vec++; if (n_done !== 8) begin n_err++; $display("FAIL b2b_done_count got %0d exp 8", n_done); end
    n_vec++; if (idx !== 8) begin n_err++; $display("FAIL b2b_accept_count got %0d exp 8", idx); end
  endtask

  task automatic test_safety();
    n_vec++; if (viol !== 0) begin n_err++; $display("FAIL safety_a got %0d exp 0", viol); end
    n_vec++; if (viol_b !== 0) begin n_err++; $display("FAIL safety_b got %0d exp 0", viol_b); end
  endtask

  initial begin
    test_reset();
    test_write_full();
    test_write_masked();
    test_clr_pending();
    test_reset_mid();
    test_back_to_back();
    test_safety();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule
